// File: rtl/hack_alu_seq.sv
// rtl/hack_alu_seq.sv - multi-cycle Hack ALU with multiply and shifts over valid/ready handshakes
module hack_alu_seq #(
  parameter int WIDTH = 16,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             busy
);

  // The counter must be able to hold WIDTH itself (multiply step count).
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       mode_r;
  logic             no_r;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] xp, yp, hack_r, direct_r, direct_out, step_acc, run_out;
  logic [SW-1:0]    n;
  logic             accept, direct_done, last_step;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);

  // Operand pre-processing, single-cycle results and handshake decode.
  always_comb begin
    xp          = zx ? (nx ? {WIDTH{1'b1}} : {WIDTH{1'b0}}) : (nx ? ~x : x);
    yp          = zy ? (ny ? {WIDTH{1'b1}} : {WIDTH{1'b0}}) : (ny ? ~y : y);
    hack_r      = f ? (xp + yp) : (xp & yp);
    n           = yp[SW-1:0];
    accept      = in_valid && (state == IDLE);
    // A zero-length shift finishes like a Hack op: the result is just xp.
    direct_done = (mode == 2'b00) || ((mode != 2'b01) && (n == '0));
    direct_r    = (mode == 2'b00) ? hack_r : xp;
    direct_out  = no ? ~direct_r : direct_r;
    last_step   = (state == RUN) && (cnt == CW'(1));
  end

  // One iteration of the sequential operation held in mode_r.
  always_comb begin
    step_acc = acc;
    case (mode_r)
      2'b01:   step_acc = mplier[0] ? (acc + mcand) : acc;
      2'b10:   step_acc = {acc[WIDTH-2:0], 1'b0};
      2'b11:   step_acc = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: step_acc = acc;
    endcase
    run_out = no_r ? ~step_acc : step_acc;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = direct_done ? DONE : RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration and registered result/flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_r <= 2'b00;
      no_r   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      out    <= '0;
      zr     <= 1'b1;
      ng     <= 1'b0;
    end else if (accept) begin
      mode_r <= mode;
      no_r   <= no;
      mcand  <= xp;
      mplier <= yp;
      acc    <= (mode == 2'b01) ? '0 : xp;
      cnt    <= (mode == 2'b01) ? CW'(WIDTH) : CW'(n);
      if (direct_done) begin
        out <= direct_out;
        zr  <= (direct_out == '0);
        ng  <= direct_out[WIDTH-1];
      end
    end else if (state == RUN) begin
      acc    <= step_acc;
      mcand  <= {mcand[WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
      cnt    <= cnt - CW'(1);
      if (last_step) begin
        out <= run_out;
        zr  <= (run_out == '0);
        ng  <= run_out[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_hack_alu_seq.sv
// tb/tb_hack_alu_seq.sv - randomized self-checking bench for hack_alu_seq
module tb_hack_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x, y;
  logic         zx, nx, zy, ny, f, no;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         zr, ng, busy;

  int n_pass = 0;
  int n_total = 0;

  hack_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zr(zr), .ng(ng), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: ctrl = {zx,nx,zy,ny,f,no}
  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [5:0] ctrl, input logic [1:0] m);
    logic [W-1:0] xp, yp, r;
    logic [31:0]  prod;
    int           sh;
    xp = ctrl[5] ? (ctrl[4] ? 16'hFFFF : 16'h0000) : (ctrl[4] ? ~a : a);
    yp = ctrl[3] ? (ctrl[2] ? 16'hFFFF : 16'h0000) : (ctrl[2] ? ~b : b);
    sh = int'(yp) % W;
    prod = 32'(xp) * 32'(yp);
    case (m)
      2'd0:    r = ctrl[1] ? xp + yp : xp & yp;
      2'd1:    r = prod[W-1:0];
      2'd2:    r = xp << sh;
      default: r = $signed(xp) >>> sh;
    endcase
    return ctrl[0] ? ~r : r;
  endfunction

  function automatic int exp_latency(input logic [W-1:0] b, input logic [5:0] ctrl,
                                     input logic [1:0] m);
    logic [W-1:0] yp;
    int sh;
    yp = ctrl[3] ? (ctrl[2] ? 16'hFFFF : 16'h0000) : (ctrl[2] ? ~b : b);
    sh = int'(yp) % W;
    if (m == 2'd0) return 1;
    if (m == 2'd1) return W;
    return (sh == 0) ? 1 : sh;
  endfunction

  task automatic present(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [5:0] ctrl, input logic [1:0] m);
    x = a; y = b; {zx, nx, zy, ny, f, no} = ctrl; mode = m; in_valid = 1'b1;
  endtask

  // Accepts one op and waits for its result; leaves the DUT in DONE.
  task automatic issue(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [5:0] ctrl, input logic [1:0] m, output logic ok);
    logic [W-1:0] e;
    int busy_cnt;
    int lat;
    ok = 1'b0;
    for (int i = 0; i < 50 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!in_ready) begin
      check({tag, "_ready_timeout"}, 0, 1);
      return;
    end
    present(a, b, ctrl, m);
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = W'($urandom); y = W'($urandom); mode = 2'($urandom);
    {zx, nx, zy, ny, f, no} = 6'($urandom);
    busy_cnt = 0;
    for (int i = 0; i < 100 && !out_valid; i++) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
    end
    if (!out_valid) begin
      check({tag, "_done_timeout"}, 0, 1);
      return;
    end
    e = model(a, b, ctrl, m);
    lat = (busy_cnt == 0) ? 1 : busy_cnt;
    check({tag, "_out"}, 32'(out), 32'(e));
    check({tag, "_zr"}, 32'(zr), 32'(e == 0));
    check({tag, "_ng"}, 32'(ng), 32'(e[W-1]));
    check({tag, "_lat"}, 32'(lat), 32'(exp_latency(b, ctrl, m)));
    ok = 1'b1;
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_in_ready_after"}, 32'(in_ready), 1);
    check({tag, "_out_valid_after"}, 32'(out_valid), 0);
  endtask

  initial begin
    logic ok;
    logic [W-1:0] held_out;
    logic held_zr, held_ng;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    present(0, 0, 0, 0); in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out", 32'(out), 0);
    check("rst_zr", 32'(zr), 1);
    check("rst_ng", 32'(ng), 0);

    issue("add", 16'd5, 16'd3, 6'b000010, 2'd0, ok);
    if (ok) release_result("add");
    issue("sub", 16'd3, 16'd5, 6'b010011, 2'd0, ok);
    if (ok) release_result("sub");
    issue("zero", 16'h1234, 16'h5678, 6'b101010, 2'd0, ok);
    if (ok) release_result("zero");
    issue("mul", 16'd300, 16'd300, 6'b000000, 2'd1, ok);
    check("mul_const", 32'(out), 32'h5F90);
    if (ok) release_result("mul");
    issue("sra", 16'h8000, 16'd3, 6'b000000, 2'd3, ok);
    check("sra_const", 32'(out), 32'hF000);
    if (ok) release_result("sra");
    issue("sll", 16'h0001, 16'h0014, 6'b000000, 2'd2, ok);
    check("sll_const", 32'(out), 32'h0010);
    if (ok) release_result("sll");
    issue("sll0", 16'hA5C3, 16'h0000, 6'b000000, 2'd2, ok);
    if (ok) release_result("sll0");

    // Backpressure: result must hold while a competing op is offered.
    issue("bp", 16'd7, 16'd9, 6'b000010, 2'd0, ok);
    held_out = out; held_zr = zr; held_ng = ng;
    present(16'hFFFF, 16'h0001, 6'b000010, 2'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_hold", 32'(out), 32'(held_out));
      check("bp_zr_hold", 32'(zr), 32'(held_zr));
      check("bp_ng_hold", 32'(ng), 32'(held_ng));
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_out_valid", 32'(out_valid), 1);
    end
    in_valid = 1'b0;
    release_result("bp");
    check("bp_no_phantom", 32'(busy), 0);
    check("bp_out_kept", 32'(out), 32'(held_out));

    // Reset during the 8th RUN cycle of a multiply.
    present(16'd300, 16'd300, 6'b000000, 2'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mr_busy_before", 32'(busy), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mr_in_ready", 32'(in_ready), 1);
    check("mr_out_valid", 32'(out_valid), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_out", 32'(out), 0);
    check("mr_zr", 32'(zr), 1);
    check("mr_ng", 32'(ng), 0);
    issue("post_rst_add", 16'd100, 16'd23, 6'b000010, 2'd0, ok);
    if (ok) release_result("post_rst_add");

    // Randomized operations with random consumer stalls.
    for (int t = 0; t < 60; t++) begin
      issue("rnd", W'($urandom), W'($urandom), 6'($urandom), 2'($urandom), ok);
      if (!ok) break;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      release_result("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
